// File: rtl/reg_arb_pkg.sv
//==============================================================================
// reg_arb_pkg : shared FSM encoding and default widths for reg_load_arbiter
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam int NREQ_DEF = 4;
  localparam int NREG_DEF = 4;
  localparam int AW_DEF   = 2;
  localparam int DW_DEF   = 4;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//==============================================================================
// rr_arbiter : combinational requester selector, one-hot grant plus index.
//              ARB_FIXED_PRI_EN selects fixed lowest-index priority (no pointer).
// Revision   : 1.0  initial release
//==============================================================================
`default_nettype none

module rr_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
`ifndef ARB_FIXED_PRI_EN
  input  logic [IW-1:0]   ptr_i,
`endif
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

`ifdef ARB_FIXED_PRI_EN
  function automatic int slot(input int off);
    return off;
  endfunction
`else
  function automatic int slot(input int off, input logic [IW-1:0] ptr);
    return (int'(ptr) + off) % NREQ;
  endfunction
`endif

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
`ifdef ARB_FIXED_PRI_EN
      if (!valid_o && req_i[slot(off)]) begin
        valid_o          = 1'b1;
        gnt_o[slot(off)] = 1'b1;
        idx_o            = IW'(slot(off));
      end
`else
      if (!valid_o && req_i[slot(off, ptr_i)]) begin
        valid_o                 = 1'b1;
        gnt_o[slot(off, ptr_i)] = 1'b1;
        idx_o                   = IW'(slot(off, ptr_i));
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_load_arbiter.sv
//==============================================================================
// reg_load_arbiter : shares a bank of load-enabled registers among requesters;
//                    IDLE -> LOAD -> ACK, one transfer per three cycles.
//                    ARB_FIXED_PRI_EN selects fixed priority instead of round-robin.
// Revision         : 1.0  initial release
//==============================================================================
`default_nettype none

module reg_load_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic [NREG-1:0]    load,
  output logic [DW-1:0]      da,
  output logic               busy,
  output logic [7:0]         xfer_cnt
);

  localparam int IW = idx_w(NREQ);

  logic [NREQ-1:0] gnt_w;
  logic [IW-1:0]   gidx_w;
  logic            gvalid_w;

  state_e          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] ack_q;
  logic [NREG-1:0] load_q;
  logic [NREG-1:0] load_d;
  logic [DW-1:0]   da_q;
  logic [DW-1:0]   da_d;
  logic [AW-1:0]   addr_d;
  logic            busy_q;
  logic [7:0]      cnt_q;

`ifdef ARB_FIXED_PRI_EN
  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i   (req),
    .gnt_o   (gnt_w),
    .idx_o   (gidx_w),
    .valid_o (gvalid_w)
  );
`else
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt_w),
    .idx_o   (gidx_w),
    .valid_o (gvalid_w)
  );

  assign ptr_d = (gidx_w == IW'(NREQ - 1)) ? '0 : gidx_w + IW'(1);
`endif

  // Addresses at or beyond NREG decode to no strobe at all.
  always_comb begin
    addr_d = req_addr[int'(gidx_w)*AW +: AW];
    da_d   = req_data[int'(gidx_w)*DW +: DW];
    load_d = '0;
    for (int r = 0; r < NREG; r++) begin
      if (addr_d == AW'(r)) load_d[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      load_q  <= '0;
      da_q    <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= 8'd0;
`ifndef ARB_FIXED_PRI_EN
      ptr_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (gvalid_w) begin
            gnt_q   <= gnt_w;
            load_q  <= load_d;
            da_q    <= da_d;
            busy_q  <= 1'b1;
            state_q <= LOAD;
`ifndef ARB_FIXED_PRI_EN
            ptr_q   <= ptr_d;
`endif
          end
        end
        LOAD: begin
          load_q  <= '0;
          ack_q   <= gnt_q;
          cnt_q   <= cnt_q + 8'd1;
          state_q <= ACK;
        end
        ACK: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ack_q   <= '0;
          load_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack      = ack_q;
  assign load     = load_q;
  assign da       = da_q;
  assign busy     = busy_q;
  assign xfer_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_load_arbiter.sv
//==============================================================================
// tb_reg_load_arbiter : directed vector bench for reg_load_arbiter
// Revision            : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_reg_load_arbiter;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [3:0]  req;
  logic [7:0]  req_addr;
  logic [15:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  load;
  logic [3:0]  da;
  logic        busy;
  logic [7:0]  xfer_cnt;

  logic [3:0]  req3;
  logic [7:0]  req_addr3;
  logic [15:0] req_data3;
  logic [3:0]  ack3;
  logic [2:0]  load3;
  logic [3:0]  da3;
  logic        busy3;
  logic [7:0]  xfer_cnt3;

  always #5 clk = ~clk;

  reg_load_arbiter dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .ack      (ack),
    .load     (load),
    .da       (da),
    .busy     (busy),
    .xfer_cnt (xfer_cnt)
  );

  reg_load_arbiter #(.NREQ(4), .NREG(3), .AW(2), .DW(4)) dut3 (
    .clk      (clk),
    .clr_n    (clr_n),
    .req      (req3),
    .req_addr (req_addr3),
    .req_data (req_data3),
    .ack      (ack3),
    .load     (load3),
    .da       (da3),
    .busy     (busy3),
    .xfer_cnt (xfer_cnt3)
  );

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [3:0]  exp_ack;
    logic [3:0]  exp_load;
    logic [3:0]  exp_da;
  } vec_t;

  vec_t tbl[6];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called with the DUT idle, one time unit after a rising edge.
  task automatic do_xfer(input vec_t v, input logic [7:0] cnt_exp, input int idx);
    req      = v.req;
    req_addr = v.addr;
    req_data = v.data;
    step();
    chk($sformatf("v%0d load", idx), load, v.exp_load);
    chk($sformatf("v%0d da", idx), da, v.exp_da);
    chk($sformatf("v%0d busy_load", idx), busy, 1'b1);
    chk($sformatf("v%0d ack_load", idx), ack, 4'h0);
    req      = 4'h0;
    req_addr = ~v.addr;
    req_data = ~v.data;
    step();
    chk($sformatf("v%0d ack", idx), ack, v.exp_ack);
    chk($sformatf("v%0d load_ack", idx), load, 4'h0);
    chk($sformatf("v%0d cnt", idx), xfer_cnt, cnt_exp);
    chk($sformatf("v%0d da_hold", idx), da, v.exp_da);
    step();
    chk($sformatf("v%0d busy_idle", idx), busy, 1'b0);
    chk($sformatf("v%0d ack_idle", idx), ack, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int g;

    tbl[0] = '{4'b0010, 8'h08, 16'h00B0, 4'b0010, 4'b0100, 4'hB};
`ifdef ARB_FIXED_PRI_EN
    tbl[1] = '{4'b0011, 8'h0D, 16'h0073, 4'b0001, 4'b0010, 4'h3};
    tbl[2] = '{4'b1010, 8'hC0, 16'h90C0, 4'b0010, 4'b0001, 4'hC};
    tbl[3] = '{4'b1001, 8'hC2, 16'hE001, 4'b0001, 4'b0100, 4'h1};
    tbl[4] = '{4'b0100, 8'h10, 16'h0500, 4'b0100, 4'b0010, 4'h5};
    tbl[5] = '{4'b1111, 8'hE4, 16'hBA98, 4'b0001, 4'b0001, 4'h8};
`else
    tbl[1] = '{4'b0011, 8'h0D, 16'h0073, 4'b0001, 4'b0010, 4'h3};
    tbl[2] = '{4'b1010, 8'hC0, 16'h90C0, 4'b0010, 4'b0001, 4'hC};
    tbl[3] = '{4'b1001, 8'hC2, 16'hE001, 4'b1000, 4'b1000, 4'hE};
    tbl[4] = '{4'b0100, 8'h10, 16'h0500, 4'b0100, 4'b0010, 4'h5};
    tbl[5] = '{4'b1111, 8'hE4, 16'hBA98, 4'b1000, 4'b1000, 4'hB};
`endif

    clr_n     = 1'b0;
    req       = 4'h0;
    req_addr  = 8'h0;
    req_data  = 16'h0;
    req3      = 4'h0;
    req_addr3 = 8'h0;
    req_data3 = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {ack, load, da, busy, xfer_cnt}, 0);
    clr_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("idle c%0d", i), {ack, load, da, busy, xfer_cnt}, 0);
    end

    for (int i = 0; i < 6; i++) do_xfer(tbl[i], 8'(i + 1), i);

    // Continuous contention with the pointer back at zero.
    req      = 4'b1111;
    req_addr = 8'hE4;
    req_data = 16'hBA98;
    for (int t = 0; t < 5; t++) begin
`ifdef ARB_FIXED_PRI_EN
      g = 0;
`else
      g = t % 4;
`endif
      step();
      chk($sformatf("cont%0d load", t), load, 4'b0001 << g);
      chk($sformatf("cont%0d da", t), da, 8 + g);
      step();
      chk($sformatf("cont%0d ack", t), ack, 4'b0001 << g);
      step();
      chk($sformatf("cont%0d busy_idle", t), busy, 1'b0);
      if (t == 4) req = 4'h0;
    end
    chk("cont cnt", xfer_cnt, 8'd11);
    step();
    chk("cont idle after drop", busy, 1'b0);

    // Out-of-range address on the three-register instance.
    req3      = 4'b0001;
    req_addr3 = 8'h03;
    req_data3 = 16'h0006;
    step();
    chk("oor load", load3, 3'b000);
    chk("oor busy", busy3, 1'b1);
    chk("oor da", da3, 4'h6);
    req3 = 4'h0;
    step();
    chk("oor ack", ack3, 4'b0001);
    chk("oor cnt", xfer_cnt3, 8'd1);
    step();
    chk("oor idle", busy3, 1'b0);
    req3      = 4'b0010;
    req_addr3 = 8'h08;
    req_data3 = 16'h00A0;
    step();
    chk("n3 load", load3, 3'b100);
    chk("n3 da", da3, 4'hA);
    req3 = 4'h0;
    step();
    chk("n3 ack", ack3, 4'b0010);
    chk("n3 cnt", xfer_cnt3, 8'd2);
    step();

    // Reset asserted while the load strobe is up.
    req      = 4'b0001;
    req_addr = 8'h01;
    req_data = 16'h0007;
    step();
    chk("mid load", load, 4'b0010);
    #2;
    clr_n = 1'b0;
    #1;
    chk("mid rst load", load, 4'h0);
    chk("mid rst ack", ack, 4'h0);
    chk("mid rst busy", busy, 1'b0);
    chk("mid rst cnt", xfer_cnt, 8'd0);
    req = 4'h0;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    step();
    chk("mid restart idle", {busy, ack, load}, 0);

    // 256 back-to-back transfers wrap the counter.
    req      = 4'b0001;
    req_addr = 8'h00;
    req_data = 16'h0000;
    for (int n = 1; n <= 256; n++) begin
      step();
      step();
      if (n == 255) chk("wrap cnt255", xfer_cnt, 8'd255);
      if (n == 256) begin
        chk("wrap cnt0", xfer_cnt, 8'd0);
        chk("wrap ack", ack, 4'b0001);
        req = 4'h0;
      end
      step();
    end
    step();
    chk("final idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
